ws2812_write_arbiter: RTL

- Arbitrates between two independent requesters for the single LED write port (rgb_data / led_num / write) of the ws2812 serial driver.
- Requester A is the host/command path (e.g. UART decoder); requester B is the animation generator.
- Supports single-LED writes and a "fill" command that sequences writes of one colour to every LED.
- Outputs are registered and drive the driver's write port directly.

---
 rtl/ws2812_write_arbiter_if.sv | 15 +
 rtl/ws2812_write_arbiter.sv | 65 ++++++
 2 files changed

// File: rtl/ws2812_write_arbiter_if.sv
// ws2812_write_arbiter_if: two requester command ports plus the ws2812 driver write port
interface ws2812_write_arbiter_if;
  logic        a_valid, a_ready, a_fill, b_valid, b_ready, b_fill;
  logic [23:0] a_rgb, b_rgb, rgb_data;
  logic [7:0]  a_led, b_led, led_num;
  logic        write, busy, grant_b, err;
  modport master (
    output a_valid, a_rgb, a_led, a_fill, b_valid, b_rgb, b_led, b_fill,
    input  a_ready, b_ready, rgb_data, led_num, write, busy, grant_b, err
  );
  modport slave (
    input  a_valid, a_rgb, a_led, a_fill, b_valid, b_rgb, b_led, b_fill,
    output a_ready, b_ready, rgb_data, led_num, write, busy, grant_b, err
  );
endinterface

// File: rtl/ws2812_write_arbiter.sv
// ws2812_write_arbiter: round-robin arbiter of two requesters onto the ws2812 write port, with fill sequencing
module ws2812_write_arbiter #(
  parameter int NUM_LEDS = 8
) (
  input logic clk,
  input logic reset,
  ws2812_write_arbiter_if.slave bus
);
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic [8:0] N    = 9'(NUM_LEDS);
  localparam logic [7:0] LAST = 8'(NUM_LEDS - 1);
  state_t      state;
  logic [7:0]  idx;
  logic        last_b, sel_a, sel_b, acc, fill;
  logic [23:0] rgb;
  logic [7:0]  led;
  always_comb begin
    sel_a = bus.a_valid && (!bus.b_valid || last_b);
    sel_b = bus.b_valid && (!bus.a_valid || !last_b);
    acc   = (state == IDLE) && (sel_a || sel_b);
    fill  = sel_b ? bus.b_fill : bus.a_fill;
    rgb   = sel_b ? bus.b_rgb : bus.a_rgb;
    led   = sel_b ? bus.b_led : bus.a_led;
  end
  assign bus.a_ready = (state == IDLE) && sel_a;
  assign bus.b_ready = (state == IDLE) && sel_b;
  assign bus.busy    = (state == FILL);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      last_b       <= 1'b1;
      bus.grant_b  <= 1'b1;
      bus.write    <= 1'b0;
      bus.err      <= 1'b0;
      bus.rgb_data <= '0;
      bus.led_num  <= '0;
    end else begin
      bus.write <= 1'b0;
      bus.err   <= 1'b0;
      if (state == FILL) begin
        bus.led_num <= idx;
        bus.write   <= 1'b1;
        idx         <= idx + 8'd1;
        if (idx == LAST) state <= IDLE;
      end else if (acc) begin
        last_b      <= sel_b;
        bus.grant_b <= sel_b;
        if (fill) begin
          bus.rgb_data <= rgb;
          bus.led_num  <= '0;
          bus.write    <= 1'b1;
          idx          <= 8'd1;
          state        <= (NUM_LEDS > 1) ? FILL : IDLE;
        end else if ({1'b0, led} < N) begin
          bus.rgb_data <= rgb;
          bus.led_num  <= led;
          bus.write    <= 1'b1;
        end else begin
          bus.err <= 1'b1;
        end
      end
    end
  end
endmodule
